// File: rtl/tile_renderer.sv
// Tile renderer: pixel position -> tilemap read -> 8x8 4bpp pattern read -> palette index, fixed 4-clock pipeline.
// Optional scroll registers and frame-synchronised latching are enabled by defining TILE_RENDERER_SCROLL_EN.
module tile_renderer #(
    parameter int MAP_W    = 40,
    parameter int MAP_H    = 25,
    parameter int MAP_BASE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        visible,
    input  logic        frame_start,
    input  logic        reg_wen,
    input  logic [1:0]  reg_addr,
    input  logic [15:0] reg_wdata,
    output logic        map_ren,
    output logic [11:0] map_raddr,
    input  logic [7:0]  map_rdata,
    output logic [13:0] pat_addr,
    output logic        pat_ren,
    input  logic [3:0]  pat_rdata,
    output logic        pix_valid,
    output logic [3:0]  pix_color
);
    logic [10:0] sx;
    logic [10:0] sy;

`ifdef TILE_RENDERER_SCROLL_EN
    localparam logic [10:0] SX_MOD  = 11'(MAP_W * 8);
    localparam logic [10:0] SY_MOD  = 11'(MAP_H * 8);
    localparam int          X_STEPS = 1023 / (MAP_W * 8);
    localparam int          Y_STEPS = 1023 / (MAP_H * 8);

    logic [9:0]  scroll_x_reg, scroll_y_reg, live_x_reg, live_y_reg;
    logic [9:0]  scroll_x_next, scroll_y_next;
    logic [10:0] wx_chain [0:X_STEPS];
    logic [10:0] wy_chain [0:Y_STEPS];
    logic [10:0] sum_x, sum_y;
    logic        unused_bits;

    // Write data is reduced modulo the map size by an unrolled compare-subtract chain.
    assign wx_chain[0] = {1'b0, reg_wdata[9:0]};
    assign wy_chain[0] = {1'b0, reg_wdata[9:0]};
    genvar gi;
    generate
        for (gi = 0; gi < X_STEPS; gi++) begin : g_wrap_x
            assign wx_chain[gi+1] = (wx_chain[gi] >= SX_MOD) ? wx_chain[gi] - SX_MOD : wx_chain[gi];
        end
        for (gi = 0; gi < Y_STEPS; gi++) begin : g_wrap_y
            assign wy_chain[gi+1] = (wy_chain[gi] >= SY_MOD) ? wy_chain[gi] - SY_MOD : wy_chain[gi];
        end
    endgenerate

    always_comb begin
        scroll_x_next = scroll_x_reg;
        scroll_y_next = scroll_y_reg;
        if (reg_wen && reg_addr == 2'd0) scroll_x_next = wx_chain[X_STEPS][9:0];
        if (reg_wen && reg_addr == 2'd1) scroll_y_next = wy_chain[Y_STEPS][9:0];
    end

    // Live scroll takes the post-write shadow value so a coincident write lands this frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_x_reg <= '0;
            scroll_y_reg <= '0;
            live_x_reg   <= '0;
            live_y_reg   <= '0;
        end else begin
            scroll_x_reg <= scroll_x_next;
            scroll_y_reg <= scroll_y_next;
            if (frame_start) begin
                live_x_reg <= scroll_x_next;
                live_y_reg <= scroll_y_next;
            end
        end
    end

    assign sum_x = {1'b0, x} + {1'b0, live_x_reg};
    assign sum_y = {1'b0, y} + {1'b0, live_y_reg};
    assign sx    = (sum_x >= SX_MOD) ? sum_x - SX_MOD : sum_x;
    assign sy    = (sum_y >= SY_MOD) ? sum_y - SY_MOD : sum_y;
    assign unused_bits = ^{reg_wdata[15:10], wx_chain[X_STEPS][10], wy_chain[Y_STEPS][10]};
`else
    logic unused_bits;

    assign sx = {1'b0, x};
    assign sy = {1'b0, y};
    assign unused_bits = ^{frame_start, reg_wdata[15:4]};
`endif

    logic [31:0] addr_full;
    logic [2:0]  sx_d1_reg, sy_d1_reg, sx_d2_reg, sy_d2_reg;
    logic        vis_d1_reg, vis_d2_reg, vis_d3_reg;
    logic [3:0]  border_reg;
    logic        unused_addr;

    assign addr_full   = 32'(MAP_BASE) + 32'(sy[10:3]) * 32'(MAP_W) + 32'(sx[10:3]);
    assign unused_addr = ^addr_full[31:12];

    // map_rdata arrives during stage 2, aligned with the twice-delayed fine offsets.
    assign pat_addr = {map_rdata, sy_d2_reg, sx_d2_reg};
    assign pat_ren  = vis_d2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            map_ren    <= 1'b0;
            map_raddr  <= '0;
            sx_d1_reg  <= '0;
            sy_d1_reg  <= '0;
            sx_d2_reg  <= '0;
            sy_d2_reg  <= '0;
            vis_d1_reg <= 1'b0;
            vis_d2_reg <= 1'b0;
            vis_d3_reg <= 1'b0;
            border_reg <= '0;
            pix_valid  <= 1'b0;
            pix_color  <= '0;
        end else begin
            map_ren    <= visible;
            map_raddr  <= addr_full[11:0];
            sx_d1_reg  <= sx[2:0];
            sy_d1_reg  <= sy[2:0];
            vis_d1_reg <= visible;
            sx_d2_reg  <= sx_d1_reg;
            sy_d2_reg  <= sy_d1_reg;
            vis_d2_reg <= vis_d1_reg;
            vis_d3_reg <= vis_d2_reg;
            if (reg_wen && reg_addr == 2'd2) border_reg <= reg_wdata[3:0];
            pix_valid  <= vis_d3_reg;
            pix_color  <= vis_d3_reg ? pat_rdata : border_reg;
        end
    end
endmodule
